// File: rtl/id_queue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// id_queue_stage : instruction queue, head decode, forwarded operand read and
//                  registered ID/EX output with valid/ready handshake
// Revision       : 1.0
// ============================================================================
module id_queue_stage #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        if_valid_i,
  output logic                        if_ready_o,
  input  logic [XLEN-1:0]             if_pc_i,
  input  logic [31:0]                 if_insn_i,
  output logic [4:0]                  rf_rs1_addr_o,
  output logic [4:0]                  rf_rs2_addr_o,
  input  logic [XLEN-1:0]             rf_rs1_rdata_i,
  input  logic [XLEN-1:0]             rf_rs2_rdata_i,
  input  logic [NUM_FWD-1:0]          fwd_valid_i,
  input  logic [NUM_FWD*5-1:0]        fwd_rd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]     fwd_rd_wdata_i,
  input  logic                        ex_load_valid_i,
  input  logic [4:0]                  ex_load_rd_addr_i,
  input  logic                        flush_i,
  output logic                        id_valid_o,
  input  logic                        id_ready_i,
  output logic [XLEN-1:0]             id_pc_o,
  output logic [31:0]                 id_insn_o,
  output logic [4:0]                  id_rs1_addr_o,
  output logic [4:0]                  id_rs2_addr_o,
  output logic [4:0]                  id_rd_addr_o,
  output logic [XLEN-1:0]             id_rs1_rdata_o,
  output logic [XLEN-1:0]             id_rs2_rdata_o,
  output logic                        id_trap_valid_o,
  output logic [31:0]                 id_trap_mcause_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
  localparam logic [31:0]   C_MCAUSE_ILLEGAL = 32'd2;

  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] C_OPC_MISC   = 7'b0001111;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     insn_mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_rs1_rdata_q, id_rs2_rdata_q;
  logic [31:0]     id_insn_q, id_mcause_q;
  logic [4:0]      id_rs1_addr_q, id_rs2_addr_q, id_rd_addr_q;
  logic            id_trap_q;

  logic            head_valid, push, load, hazard;
  logic [31:0]     head_insn;
  logic [XLEN-1:0] head_pc;
  logic            use_rs1, use_rs2, use_rd, legal;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] op1_data, op2_data;

  // Lowest forwarding index wins, so scan from the top and let lower ones overwrite.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]              addr,
    input logic [XLEN-1:0]         rf_data,
    input logic [NUM_FWD-1:0]      fv,
    input logic [NUM_FWD*5-1:0]    fa,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fv[i] && (fa[i*5 +: 5] == addr)) r = fd[i*XLEN +: XLEN];
    end
    if (addr == 5'd0) r = '0;
    return r;
  endfunction

  assign if_ready_o = (count_q < C_DEPTH);
  assign head_valid = (count_q != '0);
  assign push       = if_valid_i && if_ready_o && !flush_i;
  assign head_insn  = insn_mem_q[rd_ptr_q];
  assign head_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    legal   = 1'b1;
    case (head_insn[6:0])
      C_OPC_OP:                  begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      C_OPC_OPIMM, C_OPC_LOAD:   begin use_rs1 = 1'b1; use_rd = 1'b1; end
      C_OPC_STORE, C_OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      C_OPC_JALR:                begin use_rs1 = 1'b1; use_rd = 1'b1; end
      C_OPC_JAL, C_OPC_LUI, C_OPC_AUIPC: use_rd = 1'b1;
      C_OPC_SYSTEM: begin
        use_rs1 = (head_insn[14:12] != 3'd0) && (head_insn[14:12] <= 3'd3);
        use_rd  = (head_insn[14:12] != 3'd0);
      end
      C_OPC_MISC: ;
      default: legal = 1'b0;
    endcase
    if (head_insn[1:0] != 2'b11) legal = 1'b0;
    dec_rs1 = (legal && use_rs1) ? head_insn[19:15] : 5'd0;
    dec_rs2 = (legal && use_rs2) ? head_insn[24:20] : 5'd0;
    dec_rd  = (legal && use_rd)  ? head_insn[11:7]  : 5'd0;
  end

  assign rf_rs1_addr_o = dec_rs1;
  assign rf_rs2_addr_o = dec_rs2;
  assign op1_data = sel_operand(dec_rs1, rf_rs1_rdata_i, fwd_valid_i, fwd_rd_addr_i, fwd_rd_wdata_i);
  assign op2_data = sel_operand(dec_rs2, rf_rs2_rdata_i, fwd_valid_i, fwd_rd_addr_i, fwd_rd_wdata_i);

  // Unused source addresses decode to 0, so comparing against them is safe.
  assign hazard = head_valid && ex_load_valid_i && (ex_load_rd_addr_i != 5'd0) &&
                  ((ex_load_rd_addr_i == dec_rs1) || (ex_load_rd_addr_i == dec_rs2));
  assign load   = head_valid && !hazard && (!id_valid_q || id_ready_i);

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    id_valid_d = id_valid_q;
    if (load)            id_valid_d = 1'b1;
    else if (id_ready_i) id_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= if_pc_i;
      insn_mem_q[wr_ptr_q] <= if_insn_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      id_valid_q     <= 1'b0;
      id_pc_q        <= '0;
      id_insn_q      <= '0;
      id_rs1_addr_q  <= '0;
      id_rs2_addr_q  <= '0;
      id_rd_addr_q   <= '0;
      id_rs1_rdata_q <= '0;
      id_rs2_rdata_q <= '0;
      id_trap_q      <= 1'b0;
      id_mcause_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (load) rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      if (load) begin
        id_pc_q        <= head_pc;
        id_insn_q      <= head_insn;
        id_rs1_addr_q  <= dec_rs1;
        id_rs2_addr_q  <= dec_rs2;
        id_rd_addr_q   <= dec_rd;
        id_rs1_rdata_q <= op1_data;
        id_rs2_rdata_q <= op2_data;
        id_trap_q      <= !legal;
        id_mcause_q    <= legal ? 32'd0 : C_MCAUSE_ILLEGAL;
      end
    end
  end

  assign id_valid_o       = id_valid_q;
  assign id_pc_o          = id_pc_q;
  assign id_insn_o        = id_insn_q;
  assign id_rs1_addr_o    = id_rs1_addr_q;
  assign id_rs2_addr_o    = id_rs2_addr_q;
  assign id_rd_addr_o     = id_rd_addr_q;
  assign id_rs1_rdata_o   = id_rs1_rdata_q;
  assign id_rs2_rdata_o   = id_rs2_rdata_q;
  assign id_trap_valid_o  = id_trap_q;
  assign id_trap_mcause_o = id_mcause_q;
  assign count_o          = count_q;

endmodule
`default_nettype wire

// File: tb/tb_id_queue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for id_queue_stage: directed scenarios with literal expectations, then
// random traffic, all compared each cycle against a queue-based reference model.
module tb_id_queue_stage;
  localparam int DEPTH   = 4;
  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;

  localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] SYS = 7'b1110011, MISC = 7'b0001111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, if_valid, if_ready, flush, id_valid, id_ready, ex_load_valid, id_trap;
  logic [31:0] if_pc, if_insn, rf_rs1_rdata, rf_rs2_rdata, id_pc, id_insn;
  logic [31:0] id_rs1_rdata, id_rs2_rdata, id_mcause;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, ex_load_rd, id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD*5-1:0]    fwd_addr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [2:0]  count;
  logic [31:0] rf [32];

  assign rf_rs1_rdata = rf[rf_rs1_addr];
  assign rf_rs2_rdata = rf[rf_rs2_addr];

  id_queue_stage #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_valid_i(if_valid), .if_ready_o(if_ready), .if_pc_i(if_pc), .if_insn_i(if_insn),
    .rf_rs1_addr_o(rf_rs1_addr), .rf_rs2_addr_o(rf_rs2_addr),
    .rf_rs1_rdata_i(rf_rs1_rdata), .rf_rs2_rdata_i(rf_rs2_rdata),
    .fwd_valid_i(fwd_valid), .fwd_rd_addr_i(fwd_addr), .fwd_rd_wdata_i(fwd_data),
    .ex_load_valid_i(ex_load_valid), .ex_load_rd_addr_i(ex_load_rd),
    .flush_i(flush), .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_pc_o(id_pc), .id_insn_o(id_insn),
    .id_rs1_addr_o(id_rs1_addr), .id_rs2_addr_o(id_rs2_addr), .id_rd_addr_o(id_rd_addr),
    .id_rs1_rdata_o(id_rs1_rdata), .id_rs2_rdata_o(id_rs2_rdata),
    .id_trap_valid_o(id_trap), .id_trap_mcause_o(id_mcause), .count_o(count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_decode(input logic [31:0] insn, output logic [4:0] a1,
                                       output logic [4:0] a2, output logic [4:0] ad,
                                       output logic trap);
    logic [6:0] op;
    logic [2:0] f3;
    logic u1, u2, ud;
    op = insn[6:0];
    f3 = insn[14:12];
    trap = !(op inside {OP, OPIMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYS, MISC});
    u1 = (op inside {OP, OPIMM, LOAD, STORE, BRANCH, JALR}) || (op == SYS && f3 inside {[3'd1:3'd3]});
    u2 = op inside {OP, STORE, BRANCH};
    ud = (op inside {OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR}) || (op == SYS && f3 != 3'd0);
    a1 = (u1 && !trap) ? insn[19:15] : 5'd0;
    a2 = (u2 && !trap) ? insn[24:20] : 5'd0;
    ad = (ud && !trap) ? insn[11:7]  : 5'd0;
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < NUM_FWD; i++)
      if (fwd_valid[i] && fwd_addr[i*5 +: 5] == a) return fwd_data[i*XLEN +: XLEN];
    return rf[a];
  endfunction

  logic [63:0] mq [$];
  bit          m_known = 0;
  logic        m_valid, m_trap;
  logic [31:0] m_pc, m_insn, m_d1, m_d2, m_mcause;
  logic [4:0]  m_a1, m_a2, m_ad;

  always @(negedge clk) begin
    logic [4:0] a1, a2, ad;
    logic trap, hz, ld, can_push;
    logic [63:0] head;
    if (m_known) begin
      check("count", count, mq.size());
      check("if_ready", if_ready, mq.size() < DEPTH);
      check("id_valid", id_valid, m_valid);
      check("id_pc", id_pc, m_pc);
      check("id_insn", id_insn, m_insn);
      check("id_rs1_addr", id_rs1_addr, m_a1);
      check("id_rs2_addr", id_rs2_addr, m_a2);
      check("id_rd_addr", id_rd_addr, m_ad);
      check("id_rs1_rdata", id_rs1_rdata, m_d1);
      check("id_rs2_rdata", id_rs2_rdata, m_d2);
      check("id_trap", id_trap, m_trap);
      check("id_mcause", id_mcause, m_mcause);
      if (mq.size() != 0) begin
        model_decode(mq[0][31:0], a1, a2, ad, trap);
        check("rf_rs1_addr", rf_rs1_addr, a1);
        check("rf_rs2_addr", rf_rs2_addr, a2);
      end
    end
    if (rst) begin
      mq.delete();
      m_valid = 0; m_pc = 0; m_insn = 0; m_a1 = 0; m_a2 = 0; m_ad = 0;
      m_d1 = 0; m_d2 = 0; m_trap = 0; m_mcause = 0;
      m_known = 1;
    end else if (m_known) begin
      if (flush) begin
        mq.delete();
        m_valid = 0;
      end else begin
        can_push = mq.size() < DEPTH;
        ld = 0;
        if (mq.size() != 0) begin
          head = mq[0];
          model_decode(head[31:0], a1, a2, ad, trap);
          hz = ex_load_valid && ex_load_rd != 5'd0 && (ex_load_rd == a1 || ex_load_rd == a2);
          ld = !hz && (!m_valid || id_ready);
          if (ld) begin
            void'(mq.pop_front());
            m_valid = 1; m_pc = head[63:32]; m_insn = head[31:0];
            m_a1 = a1; m_a2 = a2; m_ad = ad;
            m_d1 = model_operand(a1); m_d2 = model_operand(a2);
            m_trap = trap; m_mcause = trap ? 32'd2 : 32'd0;
          end
        end
        if (!ld && id_ready) m_valid = 0;
        if (if_valid && can_push) mq.push_back({if_pc, if_insn});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_valid = 0; flush = 0; ex_load_valid = 0; ex_load_rd = 0;
    fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] insn);
    if_valid = 1; if_pc = pc; if_insn = insn;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [6:0] op;
    case ($urandom_range(0, 12))
      0: op = OP;      1: op = OPIMM;  2: op = LOAD;  3: op = STORE;
      4: op = BRANCH;  5: op = JAL;    6: op = JALR;  7: op = LUI;
      8: op = AUIPC;   9: op = SYS;   10: op = MISC; 11: op = 7'b1111111;
      default: op = {5'($urandom), 2'($urandom_range(0, 2))};
    endcase
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 7)), op};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit acc;
    rst = 1; id_ready = 1; if_pc = 0; if_insn = 0;
    quiet();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF;
    repeat (3) step();
    rst = 0;
    check("reset_count", count, 0);
    check("reset_id_valid", id_valid, 0);
    check("reset_if_ready", if_ready, 1);
    check("reset_id_pc", id_pc, 0);

    // ADDI x1,x0,5 three times, latency and back-to-back throughput
    drive(32'h0, 32'h00500093); step();
    check("lat_early_valid", id_valid, 0);
    drive(32'h4, 32'h00500093); step();
    check("lat_valid", id_valid, 1);
    check("lat_pc0", id_pc, 32'h0);
    check("addi_rd", id_rd_addr, 1);
    check("addi_rs1", id_rs1_addr, 0);
    drive(32'h8, 32'h00500093); step();
    check("thru_pc4", id_pc, 32'h4);
    quiet(); step();
    check("thru_pc8", id_pc, 32'h8);
    check("addi_rs2", id_rs2_addr, 0);
    step();
    check("drain_invalid", id_valid, 0);

    // Backpressure: fill queue, extra insn held off, then drain
    id_ready = 0; k = 0;
    for (int c = 0; c < 8; c++) begin
      drive(32'h100 + 4 * k, 32'h00500013 | (32'(k + 1) << 7));
      acc = if_ready;
      step();
      if (acc) k++;
    end
    check("fill_accepted", k, 5);
    check("fill_count", count, DEPTH);
    check("fill_if_ready", if_ready, 0);
    check("fill_head_pc", id_pc, 32'h100);
    id_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (k < 6) drive(32'h100 + 4 * k, 32'h00500013 | (32'(k + 1) << 7));
      else if_valid = 0;
      acc = if_ready && if_valid;
      step();
      if (acc) k++;
    end
    check("drain_total", k, 6);
    check("drain_count", count, 0);

    // Forwarding priority: fwd0 beats fwd1 on x1; rs2 from regfile
    fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'hBB, 32'hAA};
    drive(32'h200, 32'h002081B3); step();
    if_valid = 0; step();
    check("fwdA_rs1", id_rs1_rdata, 32'hAA);
    check("fwdA_rs2", id_rs2_rdata, 32'h1002);
    check("fwdA_rd", id_rd_addr, 3);
    quiet(); step(); step();
    fwd_valid = 2'b11; fwd_addr = {5'd2, 5'd1}; fwd_data = {32'hCC, 32'hAA};
    drive(32'h204, 32'h002081B3); step();
    if_valid = 0; step();
    check("fwdB_rs1", id_rs1_rdata, 32'hAA);
    check("fwdB_rs2", id_rs2_rdata, 32'hCC);
    quiet(); step(); step();

    // Load-use stall on SW x5,0(x6)
    drive(32'h300, 32'h00532023); step();
    if_valid = 0; ex_load_valid = 1; ex_load_rd = 5'd5; step();
    check("lu_stall1_valid", id_valid, 0);
    check("lu_stall1_count", count, 1);
    step();
    check("lu_stall2_valid", id_valid, 0);
    check("lu_stall2_count", count, 1);
    ex_load_valid = 0; step();
    check("lu_cap_valid", id_valid, 1);
    check("lu_cap_pc", id_pc, 32'h300);
    check("lu_cap_rs1", id_rs1_addr, 6);
    check("lu_cap_rs2", id_rs2_addr, 5);
    check("lu_cap_count", count, 0);
    quiet(); step(); step();

    // Illegal instructions and LUI
    drive(32'h400, 32'h00000000); step();
    drive(32'h404, 32'hFFFFFFFF); step();
    check("ill0_trap", id_trap, 1);
    check("ill0_mcause", id_mcause, 2);
    check("ill0_rd", id_rd_addr, 0);
    drive(32'h408, 32'h123453B7); step();
    check("ill1_trap", id_trap, 1);
    check("ill1_rs1", id_rs1_addr, 0);
    quiet(); step();
    check("lui_trap", id_trap, 0);
    check("lui_mcause", id_mcause, 0);
    check("lui_rd", id_rd_addr, 7);
    check("lui_rs1", id_rs1_addr, 0);
    check("lui_rs2", id_rs2_addr, 0);
    step(); step();

    // Flush with concurrent push, then pointer wrap
    id_ready = 0;
    for (int c = 0; c < 4; c++) begin
      drive(32'h500 + 4 * c, 32'h00500093); step();
    end
    check("preflush_count", count, 3);
    check("preflush_valid", id_valid, 1);
    flush = 1; drive(32'hBAD0, 32'h00500093); step();
    flush = 0; if_valid = 0;
    check("flush_count", count, 0);
    check("flush_valid", id_valid, 0);
    id_ready = 1;
    for (int c = 0; c < 2 * DEPTH + 1; c++) begin
      drive(32'h600 + 4 * c, 32'h00500013 | (32'(c % 31 + 1) << 7));
      step();
      if (c == 1) check("postflush_first_pc", id_pc, 32'h600);
    end
    quiet(); repeat (4) step();
    check("wrap_count", count, 0);

    // Random traffic against the model
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    for (int c = 0; c < 1500; c++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      if_pc = $urandom & 32'hFFFF_FFFC;
      if_insn = rand_insn();
      id_ready = ($urandom_range(0, 3) != 0);
      fwd_valid = 2'($urandom);
      fwd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data = {$urandom, $urandom};
      ex_load_valid = ($urandom_range(0, 4) == 0);
      ex_load_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) rf[$urandom_range(1, 31)] = $urandom;
      step();
    end
    rst = 0; quiet(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/id_queue_stage.md
Name: id_queue_stage

Overview:
- Next-generation decode stage: an instruction queue decouples fetch from decode.
- Decodes the queue head (register usage, illegal-opcode trap) and reads the regfile with N-way priority forwarding.
- Stalls on load-use hazards.
- Captures the result in a registered ID/EX output with a valid/ready handshake. Sits between IF and EX.

Parameters:
DEPTH, 4, instruction queue entries; power of two, >= 2
XLEN, 32, PC and register data width
NUM_FWD, 2, number of forwarding sources; index 0 has highest priority

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
if_valid_i  in  1  fetch presents instruction
if_ready_o  out  1  queue can accept
if_pc_i  in  XLEN  fetched PC
if_insn_i  in  32  fetched instruction
rf_rs1_addr_o  out  5  regfile read addr 1 (combinational, from head)
rf_rs2_addr_o  out  5  regfile read addr 2
rf_rs1_rdata_i  in  XLEN  regfile data 1, combinational
rf_rs2_rdata_i  in  XLEN  regfile data 2
fwd_valid_i  in  NUM_FWD  forwarding source valid
fwd_rd_addr_i  in  NUM_FWD*5  forwarding destination regs, packed
fwd_rd_wdata_i  in  NUM_FWD*XLEN  forwarding data, packed
ex_load_valid_i  in  1  EX holds a load
ex_load_rd_addr_i  in  5  EX load destination
flush_i  in  1  discard all buffered and output state
id_valid_o  out  1  output register valid
id_ready_i  in  1  EX accepts
id_pc_o  out  XLEN  decoded PC
id_insn_o  out  32  instruction
id_rs1_addr_o, id_rs2_addr_o, id_rd_addr_o  out  5 each  used register addresses, 0 if unused
id_rs1_rdata_o, id_rs2_rdata_o  out  XLEN each  operand data after forwarding
id_trap_valid_o  out  1  illegal instruction
id_trap_mcause_o  out  32  trap cause
count_o  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset: queue empty, count_o = 0, id_valid_o = 0, all id_* data outputs 0. if_ready_o = 1 from the first post-reset cycle.
- Queue:
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push when if_valid_i && if_ready_o && !flush_i.
  - if_ready_o = (count_o < DEPTH), registered-count based. A full queue does not accept even if it pops that cycle.
  - Simultaneous push and pop leaves the count unchanged.
- Head decode (combinational):
  - Opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011, MISC-MEM 0001111.
  - rs1 used by: OP, OP-IMM, LOAD, STORE, BRANCH, JALR, SYSTEM with funct3 in {1,2,3}.
  - rs2 used by: OP, STORE, BRANCH.
  - rd used by: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, SYSTEM with funct3 != 0.
  - Unused fields output address 0.
  - Illegal when insn[1:0] != 2'b11 or opcode is not in the set above. Then trap_valid = 1, mcause = 32'd2, and all register addresses = 0.
  - For non-trapping instructions, id_trap_mcause_o = 0.
- Operand select:
  - Address 0 yields data 0.
  - Otherwise use the lowest index i with fwd_valid_i[i] && fwd_rd_addr[i] == addr; if no match, use rf data.
- Load-use stall:
  - hazard = head valid && ex_load_valid_i && ex_load_rd_addr_i != 0 && ex_load_rd_addr_i matches a used rs1 or rs2 of the head.
  - While hazard is high, the head is not popped.
- Capture:
  - load = head valid && !hazard && (!id_valid_o || id_ready_i).
  - On load: pop the head and register all decoded fields; id_valid_o = 1.
  - Else if id_ready_i: id_valid_o = 0.
  - While id_valid_o && !id_ready_i, all id_* outputs hold stable. Operand data is sampled at capture and not refreshed.
- Latency: an instruction pushed on edge t appears on id_* in the cycle after edge t+1 (2 edges minimum). Throughput is 1 per cycle when unstalled.
- Flush: on the next edge, queue is emptied (pointers and count to 0) and id_valid_o = 0. A push and a capture in the flush cycle are both discarded. Flush has priority over all events.
- Reset mid-operation has the same effect as flush, plus data outputs are cleared.

Test Plan:
- Reset, then push 3 insns (ADDI x1,x0,5 at pc 0x0/0x4/0x8) with id_ready_i=1 -> id_valid_o rises 2 edges after the first push; pcs 0x0,0x4,0x8 on consecutive cycles; rd=1, rs1=0, rs2=0.
- id_ready_i=0; push DEPTH+1 insns -> 1 in output register, if_ready_o=0 once count_o=DEPTH; extra insn held off; outputs stable; release -> in-order drain, no loss or duplication.
- ADD x3,x1,x2 with fwd0=(x1,0xAA), fwd1=(x1,0xBB), fwd1 also=(x2,0xCC) -> rs1_rdata=0xAA, rs2_rdata=0xCC; rd=3.
- ex_load rd=x5 valid for 2 cycles; head is SW x5,0(x6) -> no capture for 2 cycles, then captures; count_o unchanged during the stall (no push).
- insn 0x00000000 and opcode 1111111 -> id_trap_valid_o=1, mcause=2, all addresses 0; LUI x7 -> rs1=rs2=0, rd=7.
- 3 queued + valid output, assert flush_i with concurrent push -> next cycle count_o=0, id_valid_o=0, pushed insn absent; pointer wrap verified by 2*DEPTH+1 subsequent pushes.
